sync_fifo_flags: RTL and testbench
==================================

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter DATASIZE, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDRSIZE, default 9, address width; DEPTH = 2**ADDRSIZE entries.
REQ-003 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-004 SHALL have parameter AFULL_TH, default DEPTH-4, occupancy at or above which almost-full asserts.
REQ-005 SHALL have parameter AEMPTY_TH, default 4, occupancy at or below which almost-empty asserts.
REQ-006 SHALL have port wclk  input  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port w_rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port winc  input  1  write request.
REQ-009 SHALL have port wdata  input  DATASIZE  write data.
REQ-010 SHALL have port rinc  input  1  read request.
REQ-011 SHALL have port rdata  output  DATASIZE  read data.
REQ-012 SHALL have port rvalid  output  1  rdata qualifier.
REQ-013 SHALL have ports wfull, rempty, walmost_full, ralmost_empty  output  1 each  status flags.
REQ-014 SHALL have port count  output  ADDRSIZE+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Write SHALL be accepted when winc=1 and wfull=0; wdata stored at waddr, waddr increments modulo DEPTH.
REQ-017 Read SHALL be accepted when rinc=1 and rempty=0; raddr increments modulo DEPTH.
REQ-018 count SHALL be registered: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
REQ-019 Flags SHALL be registered and consistent with count on the same cycle: wfull = (count==DEPTH), rempty = (count==0), walmost_full = (count>=AFULL_TH), ralmost_empty = (count<=AEMPTY_TH).
REQ-020 winc=1 while wfull=1 SHALL drop the write, leave memory and pointers unchanged, and set overflow.
REQ-021 rinc=1 while rempty=1 SHALL leave pointers unchanged and set underflow.
REQ-022 Simultaneous winc/rinc when full: read accepted, write dropped, overflow set, count DEPTH-1 next cycle.
REQ-023 Simultaneous winc/rinc when empty: write accepted, read rejected, underflow set, count 1 next cycle.
REQ-024 Simultaneous accepted read and write at any other occupancy: count unchanged, both pointers advance.
REQ-025 overflow/underflow SHALL remain set until w_rst.
REQ-026 FWFT=0: rdata SHALL be registered with the head word on the edge that accepts a read, and rvalid SHALL be high for exactly the following cycle; rdata holds its value otherwise.
REQ-027 FWFT=1: rdata SHALL present the head entry whenever rempty=0, with rvalid = !rempty; an accepted read advances to the next entry on the following cycle.
REQ-028 Latency: a word written in cycle N SHALL first be visible (rempty=0) in cycle N+1.
REQ-029 Pointer wrap-around SHALL be transparent; the ADDRSIZE+1-bit pointer MSB distinguishes full from empty as a cross-check of count.

Reset
REQ-030 On w_rst=1 at a wclk edge: pointers=0, count=0, rempty=1, ralmost_empty=1, wfull=0, walmost_full=0, rvalid=0, rdata=0, overflow=0, underflow=0.
REQ-031 Reset asserted mid-operation SHALL discard all stored data; requests in the reset cycle SHALL be ignored.
REQ-032 Memory contents need not be cleared.

Structure
REQ-033 Shared package fifo_pkg SHALL hold default DATASIZE/ADDRSIZE constants and a status struct typedef (wfull, rempty, walmost_full, ralmost_empty, overflow, underflow).
REQ-034 Storage SHALL be a sub-module fifo_mem: DEPTH x DATASIZE, one synchronous write port, one read port (combinational for FWFT=1, registered for FWFT=0).
REQ-035 Elaboration SHALL reject AEMPTY_TH >= AFULL_TH or AFULL_TH > DEPTH.

Verification (bench: DATASIZE=8, ADDRSIZE=2, DEPTH=4, AFULL_TH=3, AEMPTY_TH=1)
REQ-036 Write 0x11,0x22,0x33,0x44 -> count 1,2,3,4; walmost_full at count 3; wfull at 4; 5th write 0x55 dropped, overflow=1.
REQ-037 FWFT=0, read 4 from full -> rdata 0x11,0x22,0x33,0x44 each with one-cycle rvalid; rempty at count 0; extra read sets underflow.
REQ-038 FWFT=1, single write 0xA5 -> next cycle rempty=0, rvalid=1, rdata=0xA5 without rinc.
REQ-039 Full, then winc+rinc same cycle -> count 3, overflow=1, read returns oldest word; empty, then winc+rinc -> count 1, underflow=1.
REQ-040 Ten write/read cycles wrapping pointers twice -> data order preserved, count returns to 0.
REQ-041 w_rst at count 3 with overflow set -> next cycle count 0, rempty=1, overflow=0, rvalid=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: default FIFO geometry and the registered status-flag bundle.
package fifo_pkg;
  localparam int DEF_DATASIZE = 8;
  localparam int DEF_ADDRSIZE = 9;
  typedef struct packed {
    logic wfull;
    logic rempty;
    logic walmost_full;
    logic ralmost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;
  localparam fifo_status_t RESET_STATUS = '{
    wfull: 1'b0, rempty: 1'b1, walmost_full: 1'b0,
    ralmost_empty: 1'b1, overflow: 1'b0, underflow: 1'b0
  };
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATASIZE storage, sync write, combinational or registered read.
module fifo_mem #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 9,
  parameter bit FWFT     = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                re,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);
  logic [DATASIZE-1:0] mem [1<<ADDRSIZE];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  if (FWFT) begin : g_fwft
    assign rdata = mem[raddr];
  end else begin : g_reg
    always_ff @(posedge clk)
      if (rst) rdata <= '0;
      else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with registered occupancy, status flags and sticky errors.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATASIZE  = DEF_DATASIZE,
  parameter int ADDRSIZE  = DEF_ADDRSIZE,
  parameter bit FWFT      = 1'b0,
  parameter int AFULL_TH  = (1 << ADDRSIZE) - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic                wclk,
  input  logic                w_rst,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic                wfull,
  output logic                rempty,
  output logic                walmost_full,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);
  localparam int DEPTH = 1 << ADDRSIZE;
  typedef logic [ADDRSIZE:0] ptr_t;
  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t AF_P    = ptr_t'(AFULL_TH);
  localparam ptr_t AE_P    = ptr_t'(AEMPTY_TH);
  if (AEMPTY_TH >= AFULL_TH || AFULL_TH > DEPTH) begin : g_bad_th
    $fatal(1, "sync_fifo_flags: need AEMPTY_TH < AFULL_TH <= DEPTH");
  end
  ptr_t         wptr, rptr, cnt_nxt;
  fifo_status_t st;
  logic         w_acc, r_acc, rvalid_q;
  logic [DATASIZE-1:0] mem_rdata;
  assign w_acc = winc & ~st.wfull;
  assign r_acc = rinc & ~st.rempty;
  always_comb cnt_nxt = count + (w_acc ? ptr_t'(1) : '0) - (r_acc ? ptr_t'(1) : '0);
  fifo_mem #(.DATASIZE(DATASIZE), .ADDRSIZE(ADDRSIZE), .FWFT(FWFT)) u_mem (
    .clk   (wclk),
    .rst   (w_rst),
    .we    (w_acc & ~w_rst),
    .waddr (wptr[ADDRSIZE-1:0]),
    .wdata (wdata),
    .re    (r_acc & ~w_rst),
    .raddr (rptr[ADDRSIZE-1:0]),
    .rdata (mem_rdata)
  );
  // Flags come from the next count so they line up with count in the same cycle.
  always_ff @(posedge wclk)
    if (w_rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      st       <= RESET_STATUS;
      rvalid_q <= 1'b0;
    end else begin
      wptr             <= wptr + (w_acc ? ptr_t'(1) : '0);
      rptr             <= rptr + (r_acc ? ptr_t'(1) : '0);
      count            <= cnt_nxt;
      st.wfull         <= cnt_nxt == DEPTH_P;
      st.rempty        <= cnt_nxt == '0;
      st.walmost_full  <= cnt_nxt >= AF_P;
      st.ralmost_empty <= cnt_nxt <= AE_P;
      st.overflow      <= st.overflow | (winc & st.wfull);
      st.underflow     <= st.underflow | (rinc & st.rempty);
      rvalid_q         <= r_acc;
    end
  // The extra pointer MSB separates full from empty independently of count.
  always_ff @(posedge wclk)
    assert (ptr_t'(wptr - rptr) == count && ((wptr ^ rptr) == DEPTH_P) == st.wfull);
  assign rdata         = (FWFT && st.rempty) ? '0 : mem_rdata;
  assign rvalid        = FWFT ? ~st.rempty : rvalid_q;
  assign wfull         = st.wfull;
  assign rempty        = st.rempty;
  assign walmost_full  = st.walmost_full;
  assign ralmost_empty = st.ralmost_empty;
  assign overflow      = st.overflow;
  assign underflow     = st.underflow;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed scoreboard bench for registered-read and FWFT FIFO instances.
module tb_sync_fifo_flags;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0, winc0, rinc0, rvalid0, wfull0, rempty0, waf0, rae0, ovf0, unf0;
  logic rst1, winc1, rinc1, rvalid1, wfull1, rempty1, waf1, rae1, ovf1, unf1;
  logic [7:0] wdata0, rdata0, wdata1, rdata1;
  logic [2:0] count0, count1;
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];

  sync_fifo_flags #(.DATASIZE(8), .ADDRSIZE(2), .FWFT(1'b0), .AFULL_TH(3), .AEMPTY_TH(1)) d0 (
    .wclk(clk), .w_rst(rst0), .winc(winc0), .wdata(wdata0), .rinc(rinc0),
    .rdata(rdata0), .rvalid(rvalid0), .wfull(wfull0), .rempty(rempty0),
    .walmost_full(waf0), .ralmost_empty(rae0), .count(count0),
    .overflow(ovf0), .underflow(unf0));

  sync_fifo_flags #(.DATASIZE(8), .ADDRSIZE(2), .FWFT(1'b1), .AFULL_TH(3), .AEMPTY_TH(1)) d1 (
    .wclk(clk), .w_rst(rst1), .winc(winc1), .wdata(wdata1), .rinc(rinc1),
    .rdata(rdata1), .rvalid(rvalid1), .wfull(wfull1), .rempty(rempty1),
    .walmost_full(waf1), .ralmost_empty(rae1), .count(count1),
    .overflow(ovf1), .underflow(unf1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc0(input logic w, input logic [7:0] d, input logic r);
    winc0 = w; wdata0 = d; rinc0 = r;
    @(posedge clk); #1;
    winc0 = 1'b0; rinc0 = 1'b0;
  endtask

  task automatic rd0(input logic [7:0] e);
    exp_q.push_back(e);
    cyc0(1'b0, 8'h00, 1'b1);
  endtask

  task automatic rst0_pulse();
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
  endtask

  // flags order: wfull rempty walmost_full ralmost_empty overflow underflow
  task automatic st0(input string name, input logic [2:0] c, input logic [5:0] f);
    chk({name, " count"}, 32'(count0), 32'(c));
    chk({name, " flags"}, 32'({wfull0, rempty0, waf0, rae0, ovf0, unf0}), 32'(f));
  endtask

  task automatic cyc1(input logic w, input logic [7:0] d, input logic r);
    winc1 = w; wdata1 = d; rinc1 = r;
    @(posedge clk); #1;
    winc1 = 1'b0; rinc1 = 1'b0;
  endtask

  always @(negedge clk)
    if (rvalid0 === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rdata0 unexpected rvalid actual=%0h required=none", rdata0);
      end else begin
        automatic logic [7:0] e = exp_q.pop_front();
        if (rdata0 !== e) begin
          errors++;
          $display("FAIL rdata0 order actual=%0h required=%0h", rdata0, e);
        end
      end
    end

  initial begin
    winc0 = 0; rinc0 = 0; wdata0 = 0; winc1 = 0; rinc1 = 0; wdata1 = 0;
    rst0 = 1'b1; rst1 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0; rst1 = 1'b0;
    st0("reset", 3'd0, 6'b010100);
    chk("reset rvalid", 32'(rvalid0), 32'd0);
    chk("reset rdata", 32'(rdata0), 32'd0);
    // fill to full, then overflow
    cyc0(1, 8'h11, 0); st0("w1", 3'd1, 6'b000100);
    cyc0(1, 8'h22, 0); st0("w2", 3'd2, 6'b000000);
    cyc0(1, 8'h33, 0); st0("w3", 3'd3, 6'b001000);
    cyc0(1, 8'h44, 0); st0("w4", 3'd4, 6'b101000);
    cyc0(1, 8'h55, 0); st0("w5 drop", 3'd4, 6'b101010);
    rd0(8'h11); st0("r1", 3'd3, 6'b001010);
    rd0(8'h22); st0("r2", 3'd2, 6'b000010);
    rd0(8'h33); st0("r3", 3'd1, 6'b000110);
    rd0(8'h44); st0("r4", 3'd0, 6'b010110);
    cyc0(0, 8'h00, 1); st0("r5 underflow", 3'd0, 6'b010111);
    cyc0(0, 8'h00, 0);
    chk("rdata hold", 32'(rdata0), 32'h44);
    // simultaneous at full and at empty
    rst0_pulse(); st0("reset2", 3'd0, 6'b010100);
    cyc0(1, 8'hAA, 0); cyc0(1, 8'hBB, 0); cyc0(1, 8'hCC, 0); cyc0(1, 8'hDD, 0);
    st0("fill", 3'd4, 6'b101000);
    exp_q.push_back(8'hAA);
    cyc0(1, 8'hEE, 1); st0("full wr+rd", 3'd3, 6'b001010);
    rd0(8'hBB); rd0(8'hCC); rd0(8'hDD); st0("drain", 3'd0, 6'b010110);
    cyc0(1, 8'h77, 1); st0("empty wr+rd", 3'd1, 6'b000111);
    rd0(8'h77); st0("drain2", 3'd0, 6'b010111);
    // pointer wrap twice with one word in flight
    rst0_pulse();
    cyc0(1, 8'h60, 0);
    for (int i = 1; i < 10; i++) begin
      exp_q.push_back(8'(8'h60 + i - 1));
      cyc0(1, 8'(8'h60 + i), 1);
      chk("wrap count", 32'(count0), 32'd1);
    end
    rd0(8'h69); st0("wrap end", 3'd0, 6'b010100);
    // reset mid-operation with overflow set; requests in the reset cycle ignored
    cyc0(1, 8'hC1, 0); cyc0(1, 8'hC2, 0); cyc0(1, 8'hC3, 0); cyc0(1, 8'hC4, 0);
    cyc0(1, 8'hC5, 0);
    rd0(8'hC1); st0("pre-reset", 3'd3, 6'b001010);
    rst0 = 1'b1; winc0 = 1'b1; wdata0 = 8'hDD; rinc0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0; winc0 = 1'b0; rinc0 = 1'b0;
    st0("mid reset", 3'd0, 6'b010100);
    chk("mid reset rvalid", 32'(rvalid0), 32'd0);
    cyc0(0, 8'h00, 0);
    chk("post reset count", 32'(count0), 32'd0);
    chk("queue drained", 32'(exp_q.size()), 32'd0);
    // first-word-fall-through instance
    chk("fwft reset rvalid", 32'(rvalid1), 32'd0);
    chk("fwft reset rempty", 32'(rempty1), 32'd1);
    chk("fwft reset rdata", 32'(rdata1), 32'd0);
    cyc1(1, 8'hA5, 0);
    chk("fwft rempty", 32'(rempty1), 32'd0);
    chk("fwft rvalid", 32'(rvalid1), 32'd1);
    chk("fwft rdata", 32'(rdata1), 32'hA5);
    cyc1(1, 8'h5A, 0);
    chk("fwft hold head", 32'(rdata1), 32'hA5);
    chk("fwft count", 32'(count1), 32'd2);
    cyc1(0, 8'h00, 1);
    chk("fwft advance", 32'(rdata1), 32'h5A);
    chk("fwft rvalid2", 32'(rvalid1), 32'd1);
    cyc1(0, 8'h00, 1);
    chk("fwft empty", 32'(rempty1), 32'd1);
    chk("fwft rvalid low", 32'(rvalid1), 32'd0);
    cyc1(0, 8'h00, 1);
    chk("fwft underflow", 32'(unf1), 32'd1);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
